// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NREAD combinational read ports, two write
// ports (port 1 wins on a shared address), optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]       ReadBusy,
  input  logic                   RegWrite0,
  input  logic [AW-1:0]          WriteRegister0,
  input  logic [WIDTH-1:0]       WriteData0,
  input  logic                   RegWrite1,
  input  logic [AW-1:0]          WriteRegister1,
  input  logic [WIDTH-1:0]       WriteData1,
  input  logic                   Reserve,
  input  logic [AW-1:0]          ReserveRegister,
  output logic [DEPTH-1:0]       BusyVec
);

  // An address is usable only if it names a real, non-hardwired register.
  function automatic logic isValid(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busyNext;
  logic             wrEn0;
  logic             wrEn1;
  logic             rsvEn;

  assign wrEn0 = RegWrite0 && isValid(WriteRegister0);
  assign wrEn1 = RegWrite1 && isValid(WriteRegister1);
  assign rsvEn = Reserve && isValid(ReserveRegister);

  // Reservation is applied after the write clears so a new producer keeps the bit set.
  always_comb begin
    busyNext = BusyVec;
    for (int r = 0; r < DEPTH; r++) begin
      if ((wrEn0 && 32'(WriteRegister0) == r) || (wrEn1 && 32'(WriteRegister1) == r))
        busyNext[r] = 1'b0;
      if (rsvEn && 32'(ReserveRegister) == r)
        busyNext[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BusyVec <= '0;
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      BusyVec <= busyNext;
      for (int r = 0; r < DEPTH; r++) begin
        if (wrEn1 && 32'(WriteRegister1) == r)
          regs[r] <= WriteData1;
        else if (wrEn0 && 32'(WriteRegister0) == r)
          regs[r] <= WriteData0;
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign addr = ReadRegister[p*AW +: AW];

    // Port 1 forwarding is checked last so it overrides port 0, matching storage order.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (!reset && isValid(addr)) begin
        data = regs[addr];
        busy = BusyVec[addr];
        if (BYPASS != 0 && wrEn0 && WriteRegister0 == addr) begin
          data = WriteData0;
          busy = 1'b0;
        end
        if (BYPASS != 0 && wrEn1 && WriteRegister1 == addr) begin
          data = WriteData1;
          busy = 1'b0;
        end
      end
    end

    assign ReadData[p*WIDTH +: WIDTH] = data;
    assign ReadBusy[p]                = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: one bypassing and one non-bypassing
// instance share stimulus and are checked against an array-based reference model.
module tb_regfile_mp;
  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int ZREG  = 31;

  typedef struct packed {
    logic [NREAD*WIDTH-1:0] d;
    logic [NREAD*WIDTH-1:0] dn;
    logic [NREAD-1:0]       b;
    logic [NREAD-1:0]       bn;
    logic [DEPTH-1:0]       bv;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREAD*AW-1:0]    ReadRegister;
  logic [NREAD*WIDTH-1:0] ReadData, ReadDataNb;
  logic [NREAD-1:0]       ReadBusy, ReadBusyNb;
  logic                   RegWrite0, RegWrite1, Reserve;
  logic [AW-1:0]          WriteRegister0, WriteRegister1, ReserveRegister;
  logic [WIDTH-1:0]       WriteData0, WriteData1;
  logic [DEPTH-1:0]       BusyVec, BusyVecNb;

  logic [WIDTH-1:0] model [DEPTH];
  logic [DEPTH-1:0] modelBusy;
  exp_t             exp_q[$];
  int               total = 0;
  int               bad = 0;
  event             sample_ev;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZREG), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ReadRegister(ReadRegister), .ReadData(ReadData),
    .ReadBusy(ReadBusy), .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0),
    .WriteData0(WriteData0), .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1),
    .WriteData1(WriteData1), .Reserve(Reserve), .ReserveRegister(ReserveRegister),
    .BusyVec(BusyVec)
  );

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZREG), .BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .ReadRegister(ReadRegister), .ReadData(ReadDataNb),
    .ReadBusy(ReadBusyNb), .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0),
    .WriteData0(WriteData0), .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1),
    .WriteData1(WriteData1), .Reserve(Reserve), .ReserveRegister(ReserveRegister),
    .BusyVec(BusyVecNb)
  );

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] refData(int a, bit byp);
    if (reset || a == ZREG || a >= DEPTH) return '0;
    if (byp && RegWrite1 && int'(WriteRegister1) == a) return WriteData1;
    if (byp && RegWrite0 && int'(WriteRegister0) == a) return WriteData0;
    return model[a];
  endfunction

  function automatic logic refBusy(int a, bit byp);
    if (reset || a == ZREG || a >= DEPTH) return 1'b0;
    if (byp && RegWrite0 && int'(WriteRegister0) == a) return 1'b0;
    if (byp && RegWrite1 && int'(WriteRegister1) == a) return 1'b0;
    return modelBusy[a];
  endfunction

  task automatic modelClear();
    for (int r = 0; r < DEPTH; r++) model[r] = '0;
    modelBusy = '0;
  endtask

  task automatic modelEdge();
    if (RegWrite0 && int'(WriteRegister0) != ZREG) model[WriteRegister0] = WriteData0;
    if (RegWrite1 && int'(WriteRegister1) != ZREG) model[WriteRegister1] = WriteData1;
    if (RegWrite0 && int'(WriteRegister0) != ZREG) modelBusy[WriteRegister0] = 1'b0;
    if (RegWrite1 && int'(WriteRegister1) != ZREG) modelBusy[WriteRegister1] = 1'b0;
    if (Reserve && int'(ReserveRegister) != ZREG) modelBusy[ReserveRegister] = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    RegWrite0 = 1'b0; WriteRegister0 = '0; WriteData0 = '0;
    RegWrite1 = 1'b0; WriteRegister1 = '0; WriteData1 = '0;
    Reserve = 1'b0; ReserveRegister = '0;
  endtask

  task automatic setRead(int p, int a);
    ReadRegister[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr0(int a, logic [WIDTH-1:0] d);
    RegWrite0 = 1'b1; WriteRegister0 = AW'(a); WriteData0 = d;
  endtask

  task automatic wr1(int a, logic [WIDTH-1:0] d);
    RegWrite1 = 1'b1; WriteRegister1 = AW'(a); WriteData1 = d;
  endtask

  task automatic rsv(int a);
    Reserve = 1'b1; ReserveRegister = AW'(a);
  endtask

  // Inputs are already applied; queue the expected view, let the monitor sample, then advance.
  task automatic doStep();
    exp_t e;
    int   a;
    if (reset) modelClear();
    for (int p = 0; p < NREAD; p++) begin
      a = int'(ReadRegister[p*AW +: AW]);
      e.d[p*WIDTH +: WIDTH]  = refData(a, 1'b1);
      e.dn[p*WIDTH +: WIDTH] = refData(a, 1'b0);
      e.b[p]  = refBusy(a, 1'b1);
      e.bn[p] = refBusy(a, 1'b0);
    end
    e.bv = modelBusy;
    exp_q.push_back(e);
    #2;
    -> sample_ev;
    if (!reset) modelEdge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_underflow act=0 exp=1 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        for (int p = 0; p < NREAD; p++) begin
          check($sformatf("rdata_byp[%0d]", p), ReadData[p*WIDTH +: WIDTH], e.d[p*WIDTH +: WIDTH]);
          check($sformatf("rdata_nob[%0d]", p), ReadDataNb[p*WIDTH +: WIDTH], e.dn[p*WIDTH +: WIDTH]);
          check($sformatf("rbusy_byp[%0d]", p), 64'(ReadBusy[p]), 64'(e.b[p]));
          check($sformatf("rbusy_nob[%0d]", p), 64'(ReadBusyNb[p]), 64'(e.bn[p]));
        end
        check("busyvec_byp", 64'(BusyVec), 64'(e.bv));
        check("busyvec_nob", 64'(BusyVecNb), 64'(e.bv));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] pat;
    reset = 1'b1;
    ReadRegister = '0;
    idle();
    modelClear();
    #1;
    wr0(3, 64'hDEAD);
    setRead(0, 3);
    doStep();
    reset = 1'b0;
    idle();
    doStep();

    // zero register: write and reserve are both ignored
    wr0(31, 64'hA0); rsv(31); setRead(0, 31); setRead(1, 31);
    doStep();
    idle();
    doStep();

    // both write ports on register 5: port 1 wins
    wr0(5, 64'h1111); wr1(5, 64'h2222); setRead(0, 5); setRead(1, 5);
    doStep();
    idle();
    doStep();

    // same-cycle bypass of register 2
    wr0(2, 64'd2); setRead(0, 2); setRead(1, 5);
    doStep();
    idle();
    doStep();

    // scoreboard: reserve, observe busy, write clears, reserve+write keeps busy
    rsv(7); setRead(0, 7); setRead(1, 7);
    doStep();
    idle();
    doStep();
    wr0(7, 64'd9);
    doStep();
    idle();
    doStep();
    rsv(7); wr1(7, 64'd11);
    doStep();
    idle();
    doStep();
    wr0(7, 64'd12);
    doStep();

    // pattern sweep over registers 0..30, then read all 32
    for (int i = 0; i < 31; i += 2) begin
      idle();
      wr0(i, 64'(i) * 64'h0000010204080001);
      if (i + 1 <= 30) wr1(i + 1, 64'(i + 1) * 64'h0000010204080001);
      doStep();
    end
    idle();
    for (int i = 0; i < 32; i += 2) begin
      setRead(0, i);
      setRead(1, i + 1);
      doStep();
    end

    // randomised traffic with clustered addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NREAD; p++)
        setRead(p, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0)
        wr0($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
            {$urandom, $urandom});
      if ($urandom_range(0, 2) != 0)
        wr1($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
            {$urandom, $urandom});
      if ($urandom_range(0, 1) != 0)
        rsv($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      doStep();
    end
    reset = 1'b0;

    // mid-cycle reset with live contents and an active bypass write
    idle();
    wr0(4, 64'h4444); wr1(6, 64'h6666); rsv(9);
    doStep();
    idle();
    rsv(4);
    setRead(0, 4); setRead(1, 6);
    doStep();
    reset = 1'b1;
    wr0(4, 64'hAAAA); wr1(6, 64'hBBBB);
    doStep();
    reset = 1'b0;
    idle();
    doStep();

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
